// File: rtl/onehot_decoder.sv
// Registered one-hot to binary decoder with a one-entry valid/ready output stage.
// Flags zero-hot and multi-hot words and keeps a saturating count of them.
module onehot_decoder #(
    parameter int WIDTH = 16,
    parameter int OUT_W = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] datain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] dataout,
    output logic             out_err,
    input  logic             err_clr,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    if (OUT_W != $clog2(WIDTH)) begin : g_bad_out_w
        $error("onehot_decoder: OUT_W must equal $clog2(WIDTH)");
    end

    logic [OUT_W-1:0] dec_idx;
    logic             dec_err;
    logic             accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Scanning from the top down leaves the lowest set index, which is what multi-hot words report.
    always_comb begin
        dec_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (datain[i]) begin
                dec_idx = OUT_W'(i);
            end
        end
        dec_err = (datain == '0) || ((datain & (datain - WIDTH'(1))) != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            dataout   <= '0;
            out_err   <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            dataout   <= dec_idx;
            out_err   <= dec_err;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Errors are counted at acceptance; a clear in the same cycle drops that error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count <= '0;
        end else if (err_clr) begin
            err_count <= '0;
        end else if (accept && dec_err && (err_count != CNT_MAX)) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule
